rv32i_mcu: RTL and testbench

- Single-cycle RV32I microcontroller: PC, instruction ROM, 32x32 register file, ALU, load/store unit and word-organised data RAM in one top block.
- Every instruction completes in one clock.
- Only external ports are clock and reset; programs and data are preloaded by hierarchical backdoor access into the storage arrays.

---
 rtl/rv32i_mcu.sv | 190 +++++++++++++++++++
 tb/tb_rv32i_mcu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mcu.sv
// rtl/rv32i_mcu.sv - single-cycle RV32I core with instruction ROM, register file and data RAM
// Every instruction fetches, executes and retires in one clock; storage is preloaded by backdoor.

module rv32i_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] mem [0:31];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0)
      mem[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem[raddr2];
endmodule

module rv32i_dram #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (be[i])
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = mem[addr];
endmodule

module rv32i_mcu #(
  parameter int ROM_DEPTH = 64,
  parameter int RAM_AW    = 15
) (
  input logic clk,
  input logic reset
);
  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0] rom [0:ROM_DEPTH-1];
  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, ea, ram_rdata, load_data, store_data;
  logic [31:0] rf_wdata;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [3:0]  store_be, ram_be;
  logic        rf_we, br_taken, unused_ea;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'd0, $signed(a) < $signed(b)};
      3'b011:  return {31'd0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign instr    = rom[pc[ROM_AW+1:2]];
  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign pc_plus4 = pc + 32'd4;
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'd0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  rv32i_regfile u_rf (
    .clk    (clk),
    .we     (rf_we & ~reset),
    .waddr  (instr[11:7]),
    .wdata  (rf_wdata),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // Address bits above the RAM window are deliberately ignored.
  assign ea        = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign unused_ea = &{1'b0, ea[31:RAM_AW+2]};

  rv32i_dram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .addr  (ea[RAM_AW+1:2]),
    .be    (reset ? 4'd0 : ram_be),
    .wdata (store_data),
    .rdata (ram_rdata)
  );

  assign ld_byte = ram_rdata[{ea[1:0], 3'b000} +: 8];
  assign ld_half = ea[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    load_data = ram_rdata;
    case (f3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = ram_rdata;
    endcase
  end

  always_comb begin
    store_be   = 4'd0;
    store_data = rs2_val;
    case (f3)
      3'b000: begin
        store_be   = 4'b0001 << ea[1:0];
        store_data = {4{rs2_val[7:0]}};
      end
      3'b001: begin
        store_be   = ea[1] ? 4'b1100 : 4'b0011;
        store_data = {2{rs2_val[15:0]}};
      end
      3'b010:  store_be = 4'b1111;
      default: store_be = 4'd0;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = 32'd0;
    ram_be   = 4'd0;
    pc_next  = pc_plus4;
    case (opcode)
      OP_R:     begin rf_we = 1'b1; rf_wdata = alu(f3, instr[30], rs1_val, rs2_val); end
      OP_I:     begin rf_we = 1'b1; rf_wdata = alu(f3, (f3 == 3'b101) & instr[30], rs1_val, imm_i); end
      OP_LOAD:  begin rf_we = 1'b1; rf_wdata = load_data; end
      OP_STORE: ram_be = store_be;
      OP_BRANCH: if (br_taken) pc_next = pc + imm_b;
      OP_JAL:   begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_next = pc + imm_j; end
      OP_JALR:  begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'd1; end
      OP_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
      OP_AUIPC: begin rf_we = 1'b1; rf_wdata = pc + imm_u; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= 32'd0;
    else
      pc <= pc_next;
  end
endmodule

// File: tb/tb_rv32i_mcu.sv
// tb/tb_rv32i_mcu.sv - scoreboard bench for rv32i_mcu using backdoor-loaded programs

module tb_rv32i_mcu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    string       tag;
    bit          is_ram;
    int          idx;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  localparam logic [6:0] OP_I = 7'b0010011, OP_LD = 7'b0000011;

  rv32i_mcu dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.is_ram = 1'b0; e.idx = idx; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_ram(input string tag, input int idx, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.is_ram = 1'b1; e.idx = idx; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_ram) check(e.tag, dut.u_ram.mem[e.idx], e.exp);
      else          check(e.tag, dut.u_rf.mem[e.idx], e.exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic new_test();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.rom[i] = 32'd0;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1 check("rst_pc", dut.pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int cycles);
    release_reset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  initial begin
    // R-type, including a single-edge retirement check on the first instruction
    new_test();
    dut.u_rf.mem[1] = 32'h1;        dut.u_rf.mem[2] = 32'h7FFFFFFF;
    dut.u_rf.mem[3] = 32'hFFFFFFFF; dut.u_rf.mem[4] = 32'h80000000;
    dut.u_rf.mem[5] = 32'h1F;
    for (int i = 8; i <= 17; i++) dut.u_rf.mem[i] = 32'hA5A5A5A5;
    dut.rom[0] = enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd8);
    dut.rom[1] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd9);
    dut.rom[2] = enc_r(7'h00, 5'd4, 5'd3, 3'd7, 5'd10);
    dut.rom[3] = enc_r(7'h00, 5'd3, 5'd4, 3'd6, 5'd11);
    dut.rom[4] = enc_r(7'h00, 5'd5, 5'd1, 3'd1, 5'd12);
    dut.rom[5] = enc_r(7'h00, 5'd5, 5'd4, 3'd5, 5'd13);
    dut.rom[6] = enc_r(7'h20, 5'd5, 5'd4, 3'd5, 5'd14);
    dut.rom[7] = enc_r(7'h00, 5'd2, 5'd4, 3'd2, 5'd15);
    dut.rom[8] = enc_r(7'h00, 5'd0, 5'd3, 3'd3, 5'd16);
    dut.rom[9] = enc_r(7'h00, 5'd4, 5'd3, 3'd4, 5'd17);
    release_reset();
    @(posedge clk);
    #1;
    check("lat_add_x8", dut.u_rf.mem[8], 32'h80000000);
    check("lat_sub_x9_pending", dut.u_rf.mem[9], 32'hA5A5A5A5);
    exp_reg("add", 8, 32'h80000000);  exp_reg("sub", 9, 32'h80000002);
    exp_reg("and", 10, 32'h80000000); exp_reg("or", 11, 32'hFFFFFFFF);
    exp_reg("sll", 12, 32'h80000000); exp_reg("srl", 13, 32'h1);
    exp_reg("sra", 14, 32'hFFFFFFFF); exp_reg("slt", 15, 32'h1);
    exp_reg("sltu", 16, 32'h0);       exp_reg("xor", 17, 32'h7FFFFFFF);
    exp_reg("src_x2_kept", 2, 32'h7FFFFFFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    drain();

    // Loads of every width and lane
    new_test();
    dut.u_rf.mem[1] = 32'h30000100;
    dut.u_ram.mem[32'h40] = 32'hDEADBEEF;
    dut.rom[0]  = enc_i(12'd0, 5'd1, 3'd2, 5'd2,  OP_LD);
    dut.rom[1]  = enc_i(12'd0, 5'd1, 3'd1, 5'd3,  OP_LD);
    dut.rom[2]  = enc_i(12'd2, 5'd1, 3'd1, 5'd4,  OP_LD);
    for (int i = 0; i < 4; i++) begin
      dut.rom[3 + i] = enc_i(12'(i), 5'd1, 3'd0, 5'(5 + i),  OP_LD);
      dut.rom[9 + i] = enc_i(12'(i), 5'd1, 3'd4, 5'(11 + i), OP_LD);
    end
    dut.rom[7] = enc_i(12'd0, 5'd1, 3'd5, 5'd9,  OP_LD);
    dut.rom[8] = enc_i(12'd2, 5'd1, 3'd5, 5'd10, OP_LD);
    exp_reg("lw", 2, 32'hDEADBEEF);
    exp_reg("lh0", 3, 32'hFFFFBEEF);  exp_reg("lh2", 4, 32'hFFFFDEAD);
    exp_reg("lb0", 5, 32'hFFFFFFEF);  exp_reg("lb1", 6, 32'hFFFFFFBE);
    exp_reg("lb2", 7, 32'hFFFFFFAD);  exp_reg("lb3", 8, 32'hFFFFFFDE);
    exp_reg("lhu0", 9, 32'h0000BEEF); exp_reg("lhu2", 10, 32'h0000DEAD);
    exp_reg("lbu0", 11, 32'hEF);      exp_reg("lbu1", 12, 32'hBE);
    exp_reg("lbu2", 13, 32'hAD);      exp_reg("lbu3", 14, 32'hDE);
    run(20);

    // I-type ALU, plus negative immediate and sign-filling shift cases
    new_test();
    dut.u_rf.mem[1]  = 32'h1010;
    dut.u_rf.mem[20] = 32'h80000000;
    dut.rom[0]  = enc_i(12'h001, 5'd1,  3'd0, 5'd2,  OP_I);
    dut.rom[1]  = enc_i(12'h001, 5'd1,  3'd7, 5'd3,  OP_I);
    dut.rom[2]  = enc_i(12'h001, 5'd1,  3'd6, 5'd4,  OP_I);
    dut.rom[3]  = enc_i(12'h001, 5'd1,  3'd2, 5'd5,  OP_I);
    dut.rom[4]  = enc_i(12'h001, 5'd1,  3'd3, 5'd6,  OP_I);
    dut.rom[5]  = enc_i(12'h001, 5'd1,  3'd4, 5'd7,  OP_I);
    dut.rom[6]  = enc_i(12'h001, 5'd1,  3'd1, 5'd8,  OP_I);
    dut.rom[7]  = enc_i(12'h001, 5'd1,  3'd5, 5'd9,  OP_I);
    dut.rom[8]  = enc_i(12'h401, 5'd1,  3'd5, 5'd10, OP_I);
    dut.rom[9]  = enc_i(12'h404, 5'd20, 3'd5, 5'd11, OP_I);
    dut.rom[10] = enc_i(12'hFF0, 5'd1,  3'd0, 5'd12, OP_I);
    dut.rom[11] = enc_i(12'hFFF, 5'd1,  3'd3, 5'd13, OP_I);
    dut.rom[12] = enc_i(12'h000, 5'd20, 3'd2, 5'd14, OP_I);
    exp_reg("addi", 2, 32'h1011);  exp_reg("andi", 3, 32'h0);
    exp_reg("ori", 4, 32'h1011);   exp_reg("slti", 5, 32'h0);
    exp_reg("sltiu", 6, 32'h0);    exp_reg("xori", 7, 32'h1011);
    exp_reg("slli", 8, 32'h2020);  exp_reg("srli", 9, 32'h808);
    exp_reg("srai", 10, 32'h808);  exp_reg("srai_neg", 11, 32'hF8000000);
    exp_reg("addi_neg", 12, 32'h1000); exp_reg("sltiu_max", 13, 32'h1);
    exp_reg("slti_neg", 14, 32'h1);
    run(20);

    // Stores of every width and lane, with byte preservation and read-back
    new_test();
    dut.u_rf.mem[1] = 32'h200;
    dut.u_rf.mem[2] = 32'h12345678;
    for (int i = 0; i < 7; i++) dut.u_ram.mem[32'h80 + i] = 32'd0;
    dut.u_ram.mem[32'h87] = 32'hAABBCCDD;
    dut.u_ram.mem[32'h88] = 32'h11223344;
    dut.rom[0] = enc_s(12'd0,  5'd2, 5'd1, 3'd2);
    dut.rom[1] = enc_s(12'd4,  5'd2, 5'd1, 3'd1);
    dut.rom[2] = enc_s(12'd10, 5'd2, 5'd1, 3'd1);
    dut.rom[3] = enc_s(12'd12, 5'd2, 5'd1, 3'd0);
    dut.rom[4] = enc_s(12'd17, 5'd2, 5'd1, 3'd0);
    dut.rom[5] = enc_s(12'd22, 5'd2, 5'd1, 3'd0);
    dut.rom[6] = enc_s(12'd27, 5'd2, 5'd1, 3'd0);
    dut.rom[7] = enc_s(12'd29, 5'd2, 5'd1, 3'd0);
    dut.rom[8] = enc_s(12'd34, 5'd2, 5'd1, 3'd1);
    dut.rom[9] = enc_i(12'd0, 5'd1, 3'd2, 5'd3, OP_LD);
    exp_ram("sw", 32'h80, 32'h12345678);
    exp_ram("sh0", 32'h81, 32'h00005678);  exp_ram("sh2", 32'h82, 32'h56780000);
    exp_ram("sb0", 32'h83, 32'h00000078);  exp_ram("sb1", 32'h84, 32'h00007800);
    exp_ram("sb2", 32'h85, 32'h00780000);  exp_ram("sb3", 32'h86, 32'h78000000);
    exp_ram("sb_keep", 32'h87, 32'hAABB78DD);
    exp_ram("sh_keep", 32'h88, 32'h56783344);
    exp_reg("lw_after_sw", 3, 32'h12345678);
    run(20);

    // Reset persistence, no writes while in reset, x0 immunity, zero-word NOPs
    new_test();
    dut.u_rf.mem[0]  = 32'h0;
    dut.u_rf.mem[6]  = 32'h1234;
    dut.u_rf.mem[20] = 32'hCAFEF00D;
    dut.u_rf.mem[21] = 32'h13579BDF;
    dut.u_rf.mem[22] = 32'd100;
    dut.u_rf.mem[23] = 32'hBEEF;
    dut.u_ram.mem[5] = 32'h55AA;
    dut.rom[0] = enc_i(12'd1, 5'd22, 3'd0, 5'd22, OP_I);
    dut.rom[1] = enc_i(12'd5, 5'd0,  3'd0, 5'd0,  OP_I);
    dut.rom[2] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6);
    exp_reg("keep_x20", 20, 32'hCAFEF00D);
    exp_reg("keep_x21", 21, 32'h13579BDF);
    exp_ram("keep_ram5", 5, 32'h55AA);
    exp_reg("no_wr_in_reset", 22, 32'd101);
    exp_reg("x0_raw", 0, 32'h0);
    exp_reg("x0_reads_zero", 6, 32'h0);
    exp_reg("nop_no_write", 23, 32'hBEEF);
    run(10);

    // Control flow: branches, jal/jalr links, lui, auipc
    new_test();
    for (int i = 3; i <= 15; i++) dut.u_rf.mem[i] = 32'h0;
    dut.u_rf.mem[4] = 32'hFFFFFFFF; dut.u_rf.mem[5] = 32'hFFFFFFFF;
    dut.u_rf.mem[8] = 32'hFFFFFFFF; dut.u_rf.mem[15] = 32'hFFFFFFFF;
    dut.rom[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I);
    dut.rom[1]  = enc_i(12'd5, 5'd0, 3'd0, 5'd2, OP_I);
    dut.rom[2]  = enc_b(13'd8, 5'd2, 5'd1, 3'd0);
    dut.rom[3]  = enc_i(12'd1, 5'd0, 3'd0, 5'd3, OP_I);
    dut.rom[4]  = enc_b(13'd8, 5'd2, 5'd1, 3'd1);
    dut.rom[5]  = enc_i(12'd7, 5'd0, 3'd0, 5'd4, OP_I);
    dut.rom[6]  = enc_j(21'd8, 5'd5);
    dut.rom[7]  = enc_i(12'd1, 5'd0, 3'd0, 5'd6, OP_I);
    dut.rom[8]  = enc_i(12'h02D, 5'd0, 3'd0, 5'd7, OP_I);
    dut.rom[9]  = enc_i(12'd0, 5'd7, 3'd0, 5'd8, 7'b1100111);
    dut.rom[10] = enc_i(12'd1, 5'd0, 3'd0, 5'd9, OP_I);
    dut.rom[11] = {20'h12345, 5'd10, 7'b0110111};
    dut.rom[12] = {20'h00001, 5'd11, 7'b0010111};
    dut.rom[13] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd12, OP_I);
    dut.rom[14] = enc_b(13'd8, 5'd12, 5'd1, 3'd6);
    dut.rom[15] = enc_i(12'd1, 5'd0, 3'd0, 5'd13, OP_I);
    dut.rom[16] = enc_b(13'd8, 5'd1, 5'd12, 3'd4);
    dut.rom[17] = enc_i(12'd1, 5'd0, 3'd0, 5'd14, OP_I);
    dut.rom[18] = enc_i(12'd9, 5'd0, 3'd0, 5'd15, OP_I);
    exp_reg("beq_taken_skip", 3, 32'h0);
    exp_reg("bne_not_taken", 4, 32'd7);
    exp_reg("jal_link", 5, 32'd28);
    exp_reg("jal_skip", 6, 32'h0);
    exp_reg("jalr_link", 8, 32'd40);
    exp_reg("jalr_lsb_clr", 9, 32'h0);
    exp_reg("lui", 10, 32'h12345000);
    exp_reg("auipc", 11, 32'h00001030);
    exp_reg("bltu_skip", 13, 32'h0);
    exp_reg("blt_skip", 14, 32'h0);
    exp_reg("after_branches", 15, 32'd9);
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
